// File: rtl/mux_scan_ctrl_pkg.sv
// Shared constants and types for the mux scan controller.
// The state encoding is fixed so that it matches external debug tooling.
package mux_scan_ctrl_pkg;

    localparam int n_ch  = 4;
    localparam int sel_w = 2;

    typedef enum logic [1:0] {
        st_idle   = 2'd0,
        st_settle = 2'd1,
        st_sample = 2'd2
    } state_e;

    // Counter width is max(1, clog2(settle+1)).
    function automatic int cnt_width(input int settle);
        return (settle < 2) ? 1 : $clog2(settle + 1);
    endfunction

endpackage

// File: rtl/m4to1.sv
// Plain 4-to-1 multiplexer; the scan controller drives its select lines.
module m4to1 (
    input  logic [3:0] In,
    input  logic [1:0] Sel,
    output logic       Out
);

    assign Out = In[Sel];

endmodule

// File: rtl/mux_scan_ctrl_settle_timer.sv
// Loadable down-counter; tc flags that the loaded settle interval has elapsed.
module settle_timer #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] load_val,
    output logic         tc
);

    logic [W-1:0] count_r;

    // Count register: load has priority, then decrement down to zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r <= {W{1'b0}};
        end else if (load) begin
            count_r <= load_val;
        end else if (en && (count_r != {W{1'b0}})) begin
            count_r <= count_r - W'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign tc = (count_r == {W{1'b0}});

endmodule

// File: rtl/mux_scan_ctrl.sv
// Scan controller: steps the mux select through all channels, waits SETTLE
// cycles on each, samples mux_out and publishes the word with a done pulse.
module mux_scan_ctrl
    import mux_scan_ctrl_pkg::*;
#(
    parameter int SETTLE = 1,
    parameter int N_CH   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             cont,
    input  logic             abort,
    input  logic             mux_out,
    output logic [sel_w-1:0] sel,
    output logic             busy,
    output logic             done,
    output logic [n_ch-1:0]  capture
);

    localparam int                CNT_W    = cnt_width(SETTLE);
    localparam logic [CNT_W-1:0]  LOAD_VAL = CNT_W'((SETTLE > 0) ? (SETTLE - 1) : 0);
    localparam state_e            FIRST_ST = (SETTLE > 0) ? st_settle : st_sample;
    localparam logic [sel_w-1:0]  LAST_CH  = sel_w'(N_CH - 1);

    state_e          state_r;
    logic            start_r;
    logic [n_ch-2:0] buf_r;
    logic            load_s;
    logic            en_s;
    logic            tc_s;

    // Timer reload whenever the FSM is about to begin a new channel dwell.
    always_comb begin
        load_s = 1'b0;
        en_s   = (state_r == st_settle);
        case (state_r)
            st_idle:   load_s = start_r & ~abort;
            st_sample: load_s = ~abort & ((sel != LAST_CH) | cont);
            default:   load_s = 1'b0;
        endcase
    end

    settle_timer #(
        .W(CNT_W)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (load_s),
        .en       (en_s),
        .load_val (LOAD_VAL),
        .tc       (tc_s)
    );

    // Scan FSM with registered sel/busy/done/capture; start is registered
    // once in IDLE so a scan begins one cycle after the request is seen.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= st_idle;
            start_r <= 1'b0;
            buf_r   <= {(n_ch-1){1'b0}};
            sel     <= {sel_w{1'b0}};
            busy    <= 1'b0;
            done    <= 1'b0;
            capture <= {n_ch{1'b0}};
        end else begin
            done <= 1'b0;
            case (state_r)
                st_idle: begin
                    if (start_r && !abort) begin
                        start_r <= 1'b0;
                        sel     <= {sel_w{1'b0}};
                        busy    <= 1'b1;
                        state_r <= FIRST_ST;
                    end else begin
                        start_r <= start & ~abort;
                    end
                end
                st_settle: begin
                    if (abort) begin
                        sel     <= {sel_w{1'b0}};
                        busy    <= 1'b0;
                        state_r <= st_idle;
                    end else if (tc_s) begin
                        state_r <= st_sample;
                    end else begin
                        state_r <= st_settle;
                    end
                end
                st_sample: begin
                    if (abort) begin
                        sel     <= {sel_w{1'b0}};
                        busy    <= 1'b0;
                        state_r <= st_idle;
                    end else if (sel != LAST_CH) begin
                        buf_r[sel] <= mux_out;
                        sel        <= sel + 2'd1;
                        state_r    <= FIRST_ST;
                    end else begin
                        capture <= {mux_out, buf_r};
                        done    <= 1'b1;
                        if (cont) begin
                            sel     <= {sel_w{1'b0}};
                            state_r <= FIRST_ST;
                        end else begin
                            busy    <= 1'b0;
                            state_r <= st_idle;
                        end
                    end
                end
                default: begin
                    start_r <= 1'b0;
                    sel     <= {sel_w{1'b0}};
                    busy    <= 1'b0;
                    state_r <= st_idle;
                end
            endcase
        end
    end

endmodule
